// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory pipeline stage.
package mem_pkg;

   // Access width / signedness encodings (bit 2 = zero-extend on loads)
   localparam logic [2:0] W_WORD  = 3'b000;
   localparam logic [2:0] W_HALF  = 3'b010;
   localparam logic [2:0] W_HALFU = 3'b110;
   localparam logic [2:0] W_BYTE  = 3'b011;
   localparam logic [2:0] W_BYTEU = 3'b111;

   // Writeback result select encodings
   localparam logic [2:0] RES_ALU    = 3'b000;
   localparam logic [2:0] RES_LOAD   = 3'b001;
   localparam logic [2:0] RES_PC4    = 3'b010;
   localparam logic [2:0] RES_IMM    = 3'b011;
   localparam logic [2:0] RES_TARGET = 3'b100;

   // Load/store unit states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } lsu_state_t;

   // Contents of the M pipeline register
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] pc_target;
      logic [31:0] pc_plus4;
      logic [31:0] imm_ext;
      logic [4:0]  rd;
      logic        valid;
      logic [2:0]  width_src;
      logic [2:0]  result_src;
      logic        mem_write;
      logic        reg_write;
   } memory_signals_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// data, load lane selection with sign/zero extension, and misalignment check.
module load_store_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lsb,
   input  logic [31:0] store_data,
   input  logic [31:0] read_data,
   input  logic [2:0]  width_src,
   input  logic        mem_write,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic        is_half;
   logic        is_byte;
   logic        is_unsigned;
   logic [7:0]  rd_byte [4];
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign is_half     = (width_src[1:0] == 2'b10);
   assign is_byte     = (width_src[1:0] == 2'b11);
   assign is_unsigned = width_src[2];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_byte[gi] = read_data[8*gi +: 8];
      end
   endgenerate

   assign byte_lane = rd_byte[addr_lsb];
   assign half_lane = addr_lsb[1] ? read_data[31:16] : read_data[15:0];

   // Natural alignment check; unknown width codes are treated as word
   always_comb begin
      misalign = 1'b0;
      if (is_byte)      misalign = 1'b0;
      else if (is_half) misalign = addr_lsb[0];
      else              misalign = |addr_lsb;
   end

   // Store lane steering; loads always read the full word
   always_comb begin
      be    = 4'hF;
      wdata = store_data;
      if (mem_write && is_byte) begin
         be    = 4'b0001 << addr_lsb;
         wdata = {4{store_data[7:0]}};
      end else if (mem_write && is_half) begin
         be    = 4'b0011 << addr_lsb;
         wdata = {2{store_data[15:0]}};
      end
   end

   // Load lane selection and extension
   always_comb begin
      load_data = read_data;
      if (is_byte)
         load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      else if (is_half)
         load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: M register, load/store request FSM, forwarding value.
module memory_stage
   import mem_pkg::*;
#(
   parameter int MEM_LAT_MAX = 15
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [31:0] alu_result_e_i,
   input  logic [31:0] write_data_e_i,
   input  logic [31:0] pc_target_e_i,
   input  logic [31:0] pc_plus4_e_i,
   input  logic [31:0] imm_ext_e_i,
   input  logic [4:0]  rd_e_i,
   input  logic        valid_e_i,
   input  logic [2:0]  width_src_e_i,
   input  logic [2:0]  result_src_e_i,
   input  logic        mem_write_e_i,
   input  logic        reg_write_e_i,
   input  logic        flush_m_i,
   input  logic        stall_m_i,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] alu_result_m_o,
   output logic [31:0] pc_target_m_o,
   output logic [31:0] pc_plus4_m_o,
   output logic [31:0] imm_ext_m_o,
   output logic [31:0] load_data_m_o,
   output logic [31:0] forward_data_m_o,
   output logic [4:0]  rd_m_o,
   output logic [2:0]  result_src_m_o,
   output logic [2:0]  width_src_m_o,
   output logic        reg_write_m_o,
   output logic        valid_m_o,
   output logic        mem_busy_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_LAT_MAX);

   memory_signals_t  m_reg;
   memory_signals_t  e_sig;
   lsu_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      buf_reg, buf_next;
   logic [31:0]      addr_hold_reg, wdata_hold_reg;
   logic [3:0]       be_hold_reg;
   logic             we_hold_reg;

   logic        capture, req, busy, timeout;
   logic        mem_op, pending, misalign_raw, misalign_flag, take_ack, in_idle;
   logic [31:0] addr_comb, wdata_comb, load_raw, load_ext;
   logic [3:0]  be_comb;

   // Bundle execute-stage inputs into the M register layout
   always_comb begin
      e_sig            = '0;
      e_sig.alu_result = alu_result_e_i;
      e_sig.write_data = write_data_e_i;
      e_sig.pc_target  = pc_target_e_i;
      e_sig.pc_plus4   = pc_plus4_e_i;
      e_sig.imm_ext    = imm_ext_e_i;
      e_sig.rd         = rd_e_i;
      e_sig.valid      = valid_e_i;
      e_sig.width_src  = width_src_e_i;
      e_sig.result_src = result_src_e_i;
      e_sig.mem_write  = mem_write_e_i;
      e_sig.reg_write  = reg_write_e_i;
   end

   // M register: flush beats stall
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)      m_reg <= '0;
      else if (flush_m_i)  m_reg <= '0;
      else if (!stall_m_i) m_reg <= e_sig;
   end

   assign mem_op        = m_reg.valid & (m_reg.mem_write | (m_reg.result_src == RES_LOAD));
   assign misalign_flag = mem_op & misalign_raw;
   assign pending       = mem_op & ~misalign_raw;
   assign addr_comb     = {m_reg.alu_result[31:2], 2'b00};

   load_store_align u_align (
      .addr_lsb   (m_reg.alu_result[1:0]),
      .store_data (m_reg.write_data),
      .read_data  (load_raw),
      .width_src  (m_reg.width_src),
      .mem_write  (m_reg.mem_write),
      .be         (be_comb),
      .wdata      (wdata_comb),
      .load_data  (load_ext),
      .misalign   (misalign_raw)
   );

   // FSM next state, request and stall generation
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      buf_next   = buf_reg;
      req        = 1'b0;
      busy       = 1'b0;
      timeout    = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pending) begin
               req = 1'b1;
               if (dmem_ack_i) begin
                  buf_next = dmem_rdata_i;
                  if (stall_m_i && !flush_m_i) state_next = DONE;
               end else begin
                  // Freeze the request so it survives a flush of the M register
                  busy       = 1'b1;
                  capture    = 1'b1;
                  cnt_next   = CNT_W'(1);
                  state_next = flush_m_i ? DRAIN : WAIT;
               end
            end
         end
         WAIT: begin
            req = 1'b1;
            if (dmem_ack_i) begin
               buf_next   = dmem_rdata_i;
               state_next = (stall_m_i && !flush_m_i) ? DONE : IDLE;
            end else begin
               busy = 1'b1;
               if (flush_m_i) begin
                  state_next = DRAIN;
               end else if (cnt_reg == CNT_MAX) begin
                  timeout    = 1'b1;
                  buf_next   = '0;
                  state_next = DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         DONE: begin
            if (!stall_m_i || flush_m_i) state_next = IDLE;
         end
         DRAIN: begin
            req = 1'b1;
            if (dmem_ack_i) state_next = IDLE;
            else            busy       = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state, latency counter and load buffer
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         buf_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         buf_reg   <= buf_next;
      end
   end

   // Request fields held stable while an access is outstanding
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr_hold_reg  <= '0;
         wdata_hold_reg <= '0;
         be_hold_reg    <= '0;
         we_hold_reg    <= 1'b0;
      end else if (capture) begin
         addr_hold_reg  <= addr_comb;
         wdata_hold_reg <= wdata_comb;
         be_hold_reg    <= be_comb;
         we_hold_reg    <= m_reg.mem_write;
      end
   end

   assign in_idle  = (state_reg == IDLE);
   assign take_ack = req & dmem_ack_i & (state_reg != DRAIN);
   assign load_raw = take_ack ? dmem_rdata_i : buf_reg;

   assign dmem_req_o   = req;
   assign dmem_addr_o  = in_idle ? addr_comb : addr_hold_reg;
   assign dmem_wdata_o = in_idle ? wdata_comb : wdata_hold_reg;
   assign dmem_we_o    = req & (in_idle ? m_reg.mem_write : we_hold_reg);
   assign dmem_be_o    = req ? (in_idle ? be_comb : be_hold_reg) : 4'h0;

   // Forwarding value; loads forward the address, load-use is stalled upstream
   always_comb begin
      forward_data_m_o = m_reg.alu_result;
      case (m_reg.result_src)
         RES_PC4:    forward_data_m_o = m_reg.pc_plus4;
         RES_IMM:    forward_data_m_o = m_reg.imm_ext;
         RES_TARGET: forward_data_m_o = m_reg.pc_target;
         default:    forward_data_m_o = m_reg.alu_result;
      endcase
   end

   assign alu_result_m_o = m_reg.alu_result;
   assign pc_target_m_o  = m_reg.pc_target;
   assign pc_plus4_m_o   = m_reg.pc_plus4;
   assign imm_ext_m_o    = m_reg.imm_ext;
   assign load_data_m_o  = load_ext;
   assign rd_m_o         = m_reg.rd;
   assign result_src_m_o = m_reg.result_src;
   assign width_src_m_o  = m_reg.width_src;
   assign valid_m_o      = m_reg.valid;
   assign reg_write_m_o  = m_reg.reg_write & m_reg.valid & ~misalign_flag;
   assign mem_busy_o     = busy;
   assign misalign_o     = misalign_flag;
   assign timeout_o      = timeout;

endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage with hand-computed expectations.
module tb_memory_stage;
   import mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [31:0] alu_result_e, write_data_e, pc_target_e, pc_plus4_e, imm_ext_e;
   logic [4:0]  rd_e;
   logic        valid_e, mem_write_e, reg_write_e;
   logic [2:0]  width_src_e, result_src_e;
   logic        flush_m, stall_extra, stall_m;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] alu_result_m, pc_target_m, pc_plus4_m, imm_ext_m;
   logic [31:0] load_data_m, forward_data_m;
   logic [4:0]  rd_m;
   logic [2:0]  result_src_m, width_src_m;
   logic        reg_write_m, valid_m, mem_busy, misalign, timeout;

   int n_checks = 0;
   int n_fail   = 0;

   // Minimal hazard unit: stall whenever the stage reports busy
   assign stall_m = mem_busy | stall_extra;

   memory_stage #(.MEM_LAT_MAX(15)) dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .alu_result_e_i   (alu_result_e),
      .write_data_e_i   (write_data_e),
      .pc_target_e_i    (pc_target_e),
      .pc_plus4_e_i     (pc_plus4_e),
      .imm_ext_e_i      (imm_ext_e),
      .rd_e_i           (rd_e),
      .valid_e_i        (valid_e),
      .width_src_e_i    (width_src_e),
      .result_src_e_i   (result_src_e),
      .mem_write_e_i    (mem_write_e),
      .reg_write_e_i    (reg_write_e),
      .flush_m_i        (flush_m),
      .stall_m_i        (stall_m),
      .dmem_ack_i       (dmem_ack),
      .dmem_rdata_i     (dmem_rdata),
      .dmem_req_o       (dmem_req),
      .dmem_we_o        (dmem_we),
      .dmem_addr_o      (dmem_addr),
      .dmem_wdata_o     (dmem_wdata),
      .dmem_be_o        (dmem_be),
      .alu_result_m_o   (alu_result_m),
      .pc_target_m_o    (pc_target_m),
      .pc_plus4_m_o     (pc_plus4_m),
      .imm_ext_m_o      (imm_ext_m),
      .load_data_m_o    (load_data_m),
      .forward_data_m_o (forward_data_m),
      .rd_m_o           (rd_m),
      .result_src_m_o   (result_src_m),
      .width_src_m_o    (width_src_m),
      .reg_write_m_o    (reg_write_m),
      .valid_m_o        (valid_m),
      .mem_busy_o       (mem_busy),
      .misalign_o       (misalign),
      .timeout_o        (timeout)
   );

   logic [2:0]  fw_src [4] = '{RES_ALU, RES_PC4, RES_IMM, RES_TARGET};
   logic [31:0] fw_exp [4] = '{32'h0000_1234, 32'h0000_0104, 32'h0000_0055, 32'h0000_0800};

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bubble();
      valid_e = 0; alu_result_e = 0; write_data_e = 0; pc_target_e = 0;
      pc_plus4_e = 0; imm_ext_e = 0; rd_e = 0; width_src_e = 0;
      result_src_e = 0; mem_write_e = 0; reg_write_e = 0;
   endtask

   task automatic drive_instr(input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] width, input logic [2:0] rsrc,
                              input logic mw, input logic rw);
      valid_e = 1; alu_result_e = addr; write_data_e = data; rd_e = 5'd7;
      width_src_e = width; result_src_e = rsrc; mem_write_e = mw; reg_write_e = rw;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; drive_bubble(); flush_m = 0; stall_extra = 0;
      dmem_ack = 0; dmem_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("reset: checking cleared outputs");
      check_value("rst_req", dmem_req, 0);
      check_value("rst_busy", mem_busy, 0);
      check_value("rst_valid", valid_m, 0);
      check_value("rst_load", load_data_m, 0);
      next_cycle();
      reset_n = 1;

      // Store byte, zero-wait ack
      $display("txn: store byte addr 0x1003 data 0xAB, ack same cycle");
      drive_instr(32'h1003, 32'h0000_00AB, W_BYTE, RES_ALU, 1, 0);
      next_cycle(); drive_bubble(); dmem_ack = 1;
      @(negedge clk);
      check_value("sb_req", dmem_req, 1);
      check_value("sb_we", dmem_we, 1);
      check_value("sb_be", dmem_be, 4'b1000);
      check_value("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      check_value("sb_addr", dmem_addr, 32'h0000_1000);
      check_value("sb_busy", mem_busy, 0);
      next_cycle(); dmem_ack = 0;
      @(negedge clk);
      check_value("sb_after_req", dmem_req, 0);
      check_value("sb_after_busy", mem_busy, 0);

      // Store half, zero-wait ack
      $display("txn: store half addr 0x7002 data 0xBEEF, ack same cycle");
      drive_instr(32'h7002, 32'h0000_BEEF, W_HALF, RES_ALU, 1, 0);
      next_cycle(); drive_bubble(); dmem_ack = 1;
      @(negedge clk);
      check_value("sh_be", dmem_be, 4'b1100);
      check_value("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      next_cycle(); dmem_ack = 0;

      // Load half signed, ack after three busy cycles
      $display("txn: load half signed addr 0x2002, ack after 3 cycles");
      drive_instr(32'h2002, 32'h0, W_HALF, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble();
      @(negedge clk);
      check_value("lh_addr", dmem_addr, 32'h0000_2000);
      check_value("lh_be", dmem_be, 4'hF);
      check_value("lh_we", dmem_we, 0);
      for (int i = 0; i < 3; i++) begin
         check_value($sformatf("lh_busy%0d", i), mem_busy, 1);
         check_value($sformatf("lh_req%0d", i), dmem_req, 1);
         next_cycle();
         @(negedge clk);
      end
      // now in the fourth cycle: ack arrives (set combinationally before sampling)
      dmem_ack = 1; dmem_rdata = 32'h8001_0000;
      #1;
      check_value("lh_ack_busy", mem_busy, 0);
      check_value("lh_load", load_data_m, 32'hFFFF_8001);
      check_value("lh_regwr", reg_write_m, 1);
      check_value("lh_fwd", forward_data_m, 32'h0000_2002);
      next_cycle(); dmem_ack = 0; dmem_rdata = 0;
      @(negedge clk);
      check_value("lh_after_req", dmem_req, 0);
      check_value("lh_after_valid", valid_m, 0);

      // Misaligned word load
      $display("txn: load word addr 0x3001 (misaligned)");
      drive_instr(32'h3001, 32'h0, W_WORD, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble();
      @(negedge clk);
      check_value("mis_req", dmem_req, 0);
      check_value("mis_flag", misalign, 1);
      check_value("mis_regwr", reg_write_m, 0);
      check_value("mis_busy", mem_busy, 0);
      next_cycle();
      @(negedge clk);
      check_value("mis_clear", misalign, 0);

      // Load byte signed, zero-wait ack under external stall -> DONE holds data
      $display("txn: load byte addr 0x6001, ack same cycle, stalled");
      drive_instr(32'h6001, 32'h0, W_BYTE, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble(); dmem_ack = 1; dmem_rdata = 32'h0000_F100; stall_extra = 1;
      @(negedge clk);
      check_value("lb_load", load_data_m, 32'hFFFF_FFF1);
      check_value("lb_busy", mem_busy, 0);
      next_cycle(); dmem_ack = 0; dmem_rdata = 0; stall_extra = 0;
      @(negedge clk);
      check_value("lb_done_req", dmem_req, 0);
      check_value("lb_done_load", load_data_m, 32'hFFFF_FFF1);
      next_cycle();
      @(negedge clk);
      check_value("lb_idle_valid", valid_m, 0);

      // Load byte unsigned, zero-wait
      $display("txn: load byte unsigned addr 0x6001, ack same cycle");
      drive_instr(32'h6001, 32'h0, W_BYTEU, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble(); dmem_ack = 1; dmem_rdata = 32'h0000_F100;
      @(negedge clk);
      check_value("lbu_load", load_data_m, 32'h0000_00F1);
      next_cycle(); dmem_ack = 0; dmem_rdata = 0;

      // Forwarding select for non-memory instructions
      pc_plus4_e = 32'h104; imm_ext_e = 32'h55; pc_target_e = 32'h800;
      for (int k = 0; k < 4; k++) begin
         $display("txn: forward select %0d", k);
         drive_instr(32'h1234, 32'h0, W_WORD, fw_src[k], 0, 1);
         pc_plus4_e = 32'h104; imm_ext_e = 32'h55; pc_target_e = 32'h800;
         next_cycle();
         @(negedge clk);
         check_value($sformatf("fwd%0d", k), forward_data_m, fw_exp[k]);
         check_value($sformatf("fwd_regwr%0d", k), reg_write_m, 1);
         check_value($sformatf("fwd_req%0d", k), dmem_req, 0);
         next_cycle();
      end
      drive_bubble();
      next_cycle();

      // Load with no ack -> timeout after 15 WAIT cycles
      $display("txn: load word addr 0x4000, no ack (timeout)");
      drive_instr(32'h4000, 32'h0, W_WORD, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble();
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         check_value($sformatf("to_pulse%0d", c), timeout, (c == 15) ? 1 : 0);
         check_value($sformatf("to_req%0d", c), dmem_req, 1);
         next_cycle();
      end
      @(negedge clk);
      check_value("to_done_req", dmem_req, 0);
      check_value("to_done_pulse", timeout, 0);
      check_value("to_done_busy", mem_busy, 0);
      check_value("to_done_load", load_data_m, 32'h0);
      next_cycle();
      @(negedge clk);
      check_value("to_idle_valid", valid_m, 0);

      // Flush during WAIT, ack two cycles later
      $display("txn: store word addr 0x5004, flush in WAIT, ack 2 cycles later");
      drive_instr(32'h5004, 32'h1234_5678, W_WORD, RES_ALU, 1, 0);
      next_cycle(); drive_bubble();
      next_cycle(); flush_m = 1;
      @(negedge clk);
      check_value("fl_wait_busy", mem_busy, 1);
      next_cycle(); flush_m = 0;
      @(negedge clk);
      check_value("fl_drain_req", dmem_req, 1);
      check_value("fl_drain_addr", dmem_addr, 32'h0000_5004);
      check_value("fl_drain_wdata", dmem_wdata, 32'h1234_5678);
      check_value("fl_drain_we", dmem_we, 1);
      check_value("fl_drain_busy", mem_busy, 1);
      check_value("fl_drain_valid", valid_m, 0);
      next_cycle(); dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_value("fl_ack_req", dmem_req, 1);
      check_value("fl_ack_busy", mem_busy, 0);
      next_cycle(); dmem_ack = 0; dmem_rdata = 0;
      @(negedge clk);
      check_value("fl_idle_req", dmem_req, 0);
      check_value("fl_idle_alu", alu_result_m, 32'h0);
      check_value("fl_idle_busy", mem_busy, 0);

      // Asynchronous reset in the middle of WAIT
      $display("txn: load word addr 0x8000, reset asserted in WAIT");
      drive_instr(32'h8000, 32'h0, W_WORD, RES_LOAD, 0, 1);
      next_cycle(); drive_bubble();
      next_cycle();
      @(negedge clk);
      check_value("rw_req", dmem_req, 1);
      #2 reset_n = 0;
      #1;
      check_value("rw_req_rst", dmem_req, 0);
      check_value("rw_busy_rst", mem_busy, 0);
      check_value("rw_valid_rst", valid_m, 0);
      check_value("rw_alu_rst", alu_result_m, 32'h0);
      check_value("rw_be_rst", dmem_be, 4'h0);
      next_cycle(); reset_n = 1;
      @(negedge clk);
      check_value("rw_rel_req", dmem_req, 0);
      drive_instr(32'h9008, 32'hCAFE_F00D, W_WORD, RES_ALU, 1, 0);
      next_cycle(); drive_bubble(); dmem_ack = 1;
      @(negedge clk);
      check_value("rw_idle_addr", dmem_addr, 32'h0000_9008);
      check_value("rw_idle_busy", mem_busy, 0);
      next_cycle(); dmem_ack = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
